picorv_dma_sched: RTL and testbench
===================================

Name: picorv_dma_sched

Overview:
- Descriptor-queue controller that sequences the PicoRV DMA engine on behalf of the host CPU.
- Host pushes {src, dst, len, cmd} jobs into a FIFO through a small Wishbone slave.
- The scheduler pops one job at a time, programs the DMA's gp registers through the DMA's Wishbone slave port, and waits for the DMA's completion IRQ. It then acknowledges the IRQ and starts the next job.
- Sits between the system crossbar (host side) and the DMA register port.

Parameters:
- QUEUE_DEPTH, 4, descriptor FIFO entries; power of 2, range 2..16.
- DMA_REG_BASE, 11'd1024, word address of the DMA irq_out register. gp_reg[n] is at DMA_REG_BASE+16+n.

Ports:
- sys_clk  in  1  clock
- rst  in  1  reset
- wbs_adr  in  3  host word address
- wbs_dat_w  in  32  host write data
- wbs_dat_r  out  32  host read data
- wbs_sel  in  4  byte selects; ignored, full-word access only
- wbs_cyc  in  1  host cycle
- wbs_stb  in  1  host strobe
- wbs_we  in  1  host write enable
- wbs_ack  out  1  host acknowledge
- wbs_stall  out  1  tied 0
- dma_adr_o  out  11  DMA register word address
- dma_dat_o  out  32  DMA write data
- dma_dat_i  in  32  DMA read data
- dma_we_o  out  1  DMA write enable
- dma_sel_o  out  4  always 4'hF
- dma_cyc_o  out  1  DMA cycle
- dma_stb_o  out  1  DMA strobe
- dma_ack_i  in  1  DMA acknowledge
- dma_stall_i  in  1  DMA stall
- dma_err_i  in  1  DMA bus error
- dma_irq_i  in  1  DMA irq_out
- irq_o  out  1  host interrupt

Behaviour:
- Reset: rst is synchronous, active-high; clock is sys_clk.
  - All outputs 0; FIFO empty; FSM in IDLE.
  - STATUS, IRQ and IRQ_EN registers and the done counter all 0.
- Host register map (word offsets):
  - 0 SRC (R/W)
  - 1 DST (R/W)
  - 2 LEN (R/W)
  - 3 PUSH (W: push {SRC, DST, LEN, wdata} into FIFO; R: 0)
  - 4 STATUS (RO): [0] busy (FSM != IDLE), [1] full, [2] empty, [7:3] count, [15:8] done_cnt (wraps at 255)
  - 5 IRQ (W1C): [0] done, [1] overflow, [2] bus_err
  - 6 IRQ_EN (R/W, bits [2:0])
  - 7 reads 0
- Host access timing:
  - wbs_ack pulses 1 cycle after a cyc&stb.
  - Read data is registered with the ack.
  - Writes take effect at the ack edge.
- Push while full: entry dropped, IRQ[1] set, count unchanged.
- Push while FIFO empty and FSM idle: pop happens no earlier than the cycle after the push.
- irq_o = |(IRQ & IRQ_EN), registered.
- FSM states:
  - IDLE: if FIFO not empty, pop the head into the job register and go to W_SRC.
  - W_SRC, W_DST, W_LEN, W_CMD: write job fields to gp_reg[0..3].
  - WAIT_IRQ: wait until dma_irq_i == 1.
  - R_IRQ: read DMA_REG_BASE, capturing pending bits P.
  - C_IRQ: write P back to DMA_REG_BASE (W1C in the DMA), then set IRQ[0], increment done_cnt, return to IDLE.
- DMA bus transaction rules (single outstanding):
  - Raise cyc and stb.
  - Hold stb until a cycle with !dma_stall_i, then drop stb and keep cyc.
  - Advance state on dma_ack_i and drop cyc the same edge.
  - 1 idle cycle (cyc=0) between consecutive transactions.
- dma_err_i during any transaction:
  - Abort the current job, set IRQ[2], return to IDLE.
  - Do not increment done_cnt.
- dma_irq_i already high on entering WAIT_IRQ: advance in 1 cycle (level-sensitive).
- dma_irq_i high while not in WAIT_IRQ: ignored.
- rst mid-job: immediate return to IDLE; cyc/stb drop the same edge; FIFO is flushed.
- FIFO pointers: log2(QUEUE_DEPTH)+1 bits; full when MSBs differ and LSBs are equal. Wrap-around is exercised.

Test Plan:
- Single job: SRC=0x100, DST=0x200, LEN=0x40, PUSH 0x1.
  - DMA model sees writes 1040=0x100, 1041=0x200, 1042=0x40, 1043=0x1.
  - DMA raises irq: scheduler reads 1024=0x1, writes 1024=0x1.
  - STATUS done_cnt=1, empty=1; IRQ[0]=1; irq_o=1 with IRQ_EN=1.
- Queue fill with QUEUE_DEPTH=4: push 5 jobs while DMA irq is held low.
  - STATUS full=1, count=4 (the first job is popped, so the 5th push fits).
  - A 6th push sets IRQ[1] and leaves count=4.
- Stall handling: dma_stall_i high for 3 cycles on the W_DST write.
  - stb stays high for 4 cycles; write data is unchanged; sequence completes.
- Bus error: dma_err_i asserted on the W_LEN ack.
  - No W_CMD write occurs; IRQ[2]=1; FSM returns to IDLE; next queued job starts.
- Back-to-back drain: 8 jobs, DMA irq 10 cycles after each cmd write.
  - done_cnt=8; jobs executed in FIFO order across pointer wrap.
- Reset mid-WAIT_IRQ with 2 jobs queued.
  - STATUS=0x4 (empty); dma_cyc_o=0; no further DMA writes.

Source files
------------

// File: rtl/picorv_dma_sched.sv
// picorv_dma_sched: host-fed descriptor queue that programs the PicoRV DMA
// through its register port, one job at a time, and retires each job on the
// DMA completion interrupt.
module picorv_dma_sched #(
   parameter int          QUEUE_DEPTH  = 4,
   parameter logic [10:0] DMA_REG_BASE = 11'd1024
) (
   input  logic        sys_clk,
   input  logic        rst,
   input  logic [2:0]  wbs_adr,
   input  logic [31:0] wbs_dat_w,
   output logic [31:0] wbs_dat_r,
   input  logic [3:0]  wbs_sel,
   input  logic        wbs_cyc,
   input  logic        wbs_stb,
   input  logic        wbs_we,
   output logic        wbs_ack,
   output logic        wbs_stall,
   output logic [10:0] dma_adr_o,
   output logic [31:0] dma_dat_o,
   input  logic [31:0] dma_dat_i,
   output logic        dma_we_o,
   output logic [3:0]  dma_sel_o,
   output logic        dma_cyc_o,
   output logic        dma_stb_o,
   input  logic        dma_ack_i,
   input  logic        dma_stall_i,
   input  logic        dma_err_i,
   input  logic        dma_irq_i,
   output logic        irq_o
);
   localparam int AW = $clog2(QUEUE_DEPTH);
   localparam int PW = AW + 1;

   typedef enum logic [2:0] {IDLE, W_SRC, W_DST, W_LEN, W_CMD, WAIT_IRQ, R_IRQ, C_IRQ} state_t;

   state_t         state_reg, state_next;
   logic           cyc_reg, cyc_next, stb_reg, stb_next, gap_reg, gap_next;
   logic           pop, done_set, err_set, capture;
   logic           ack_reg, irq_out_reg;
   logic [31:0]    dat_r_reg, rd_data, status;
   logic [31:0]    src_reg, dst_reg, len_reg;
   logic [2:0]     irq_reg, irq_en_reg, irq_set, irq_clr;
   logic [7:0]     done_cnt_reg;
   logic [PW-1:0]  wr_ptr_reg, rd_ptr_reg, count;
   logic           full, empty, host_req, host_wr, push;
   logic [31:0]    job_src_reg, job_dst_reg, job_len_reg, job_cmd_reg, pend_reg;
   logic [10:0]    bus_adr;
   logic [31:0]    bus_dat;
   logic           bus_we;
   logic           unused_sel;

   // Descriptor storage, one array per field
   logic [31:0] q_src [QUEUE_DEPTH];
   logic [31:0] q_dst [QUEUE_DEPTH];
   logic [31:0] q_len [QUEUE_DEPTH];
   logic [31:0] q_cmd [QUEUE_DEPTH];

   assign unused_sel = ^wbs_sel;
   assign host_req   = wbs_cyc & wbs_stb & ~ack_reg;
   assign host_wr    = host_req & wbs_we;
   assign push       = host_wr && (wbs_adr == 3'd3);
   assign count      = wr_ptr_reg - rd_ptr_reg;
   assign empty      = (wr_ptr_reg == rd_ptr_reg);
   assign full       = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                       (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
   assign status     = {16'd0, done_cnt_reg, 5'(count), empty, full, (state_reg != IDLE)};
   assign irq_set    = {err_set, push & full, done_set};
   assign irq_clr    = (host_wr && wbs_adr == 3'd5) ? wbs_dat_w[2:0] : 3'd0;

   assign wbs_ack    = ack_reg;
   assign wbs_dat_r  = dat_r_reg;
   assign wbs_stall  = 1'b0;
   assign irq_o      = irq_out_reg;
   assign dma_cyc_o  = cyc_reg;
   assign dma_stb_o  = stb_reg;
   assign dma_sel_o  = 4'hF;
   assign dma_adr_o  = bus_adr;
   assign dma_dat_o  = bus_dat;
   assign dma_we_o   = bus_we;

   // Host read multiplexer
   always_comb begin
      rd_data = 32'd0;
      case (wbs_adr)
         3'd0: rd_data = src_reg;
         3'd1: rd_data = dst_reg;
         3'd2: rd_data = len_reg;
         3'd4: rd_data = status;
         3'd5: rd_data = {29'd0, irq_reg};
         3'd6: rd_data = {29'd0, irq_en_reg};
         default: rd_data = 32'd0;
      endcase
   end

   // Host slave: one-cycle ack, read data registered with it, writes land at the ack edge
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         ack_reg    <= 1'b0;
         dat_r_reg  <= 32'd0;
         src_reg    <= 32'd0;
         dst_reg    <= 32'd0;
         len_reg    <= 32'd0;
         irq_en_reg <= 3'd0;
      end else begin
         ack_reg   <= host_req;
         dat_r_reg <= (host_req && !wbs_we) ? rd_data : 32'd0;
         if (host_wr) begin
            case (wbs_adr)
               3'd0: src_reg    <= wbs_dat_w;
               3'd1: dst_reg    <= wbs_dat_w;
               3'd2: len_reg    <= wbs_dat_w;
               3'd6: irq_en_reg <= wbs_dat_w[2:0];
               default: ;
            endcase
         end
      end
   end

   // Descriptor array write; a push into a full queue is dropped
   always_ff @(posedge sys_clk) begin
      if (push && !full) begin
         q_src[wr_ptr_reg[AW-1:0]] <= src_reg;
         q_dst[wr_ptr_reg[AW-1:0]] <= dst_reg;
         q_len[wr_ptr_reg[AW-1:0]] <= len_reg;
         q_cmd[wr_ptr_reg[AW-1:0]] <= wbs_dat_w;
      end
   end

   // Queue pointers, interrupt flags, done counter and the registered host irq
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         irq_reg      <= 3'd0;
         done_cnt_reg <= 8'd0;
         irq_out_reg  <= 1'b0;
      end else begin
         if (push && !full) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)           rd_ptr_reg <= rd_ptr_reg + 1'b1;
         irq_reg     <= (irq_reg & ~irq_clr) | irq_set;
         if (done_set) done_cnt_reg <= done_cnt_reg + 8'd1;
         irq_out_reg <= |(irq_reg & irq_en_reg);
      end
   end

   // Job register loaded on pop; DMA pending bits captured on the read ack
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         job_src_reg <= 32'd0;
         job_dst_reg <= 32'd0;
         job_len_reg <= 32'd0;
         job_cmd_reg <= 32'd0;
         pend_reg    <= 32'd0;
      end else begin
         if (pop) begin
            job_src_reg <= q_src[rd_ptr_reg[AW-1:0]];
            job_dst_reg <= q_dst[rd_ptr_reg[AW-1:0]];
            job_len_reg <= q_len[rd_ptr_reg[AW-1:0]];
            job_cmd_reg <= q_cmd[rd_ptr_reg[AW-1:0]];
         end
         if (capture) pend_reg <= dma_dat_i;
      end
   end

   // Sequencer state and DMA bus handshake registers
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state_reg <= IDLE;
         cyc_reg   <= 1'b0;
         stb_reg   <= 1'b0;
         gap_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         cyc_reg   <= cyc_next;
         stb_reg   <= stb_next;
         gap_reg   <= gap_next;
      end
   end

   // Next state: each bus state runs one transaction, with one idle cycle after each ack
   always_comb begin
      state_next = state_reg;
      cyc_next   = cyc_reg;
      stb_next   = stb_reg;
      gap_next   = 1'b0;
      pop        = 1'b0;
      done_set   = 1'b0;
      err_set    = 1'b0;
      capture    = 1'b0;
      case (state_reg)
         IDLE: begin
            if (!empty) begin
               pop        = 1'b1;
               state_next = W_SRC;
            end
         end
         WAIT_IRQ: begin
            if (dma_irq_i) state_next = R_IRQ;
         end
         default: begin
            if (!cyc_reg) begin
               if (!gap_reg) begin
                  cyc_next = 1'b1;
                  stb_next = 1'b1;
               end
            end else if (dma_err_i) begin
               cyc_next   = 1'b0;
               stb_next   = 1'b0;
               err_set    = 1'b1;
               state_next = IDLE;
            end else if (dma_ack_i) begin
               cyc_next = 1'b0;
               stb_next = 1'b0;
               gap_next = 1'b1;
               case (state_reg)
                  W_SRC:   state_next = W_DST;
                  W_DST:   state_next = W_LEN;
                  W_LEN:   state_next = W_CMD;
                  W_CMD:   state_next = WAIT_IRQ;
                  R_IRQ: begin
                     capture    = 1'b1;
                     state_next = C_IRQ;
                  end
                  C_IRQ: begin
                     done_set   = 1'b1;
                     state_next = IDLE;
                  end
                  default: state_next = IDLE;
               endcase
            end else if (stb_reg && !dma_stall_i) begin
               stb_next = 1'b0;
            end
         end
      endcase
   end

   // DMA address/data for the transaction of the current state, quiet when no cycle
   always_comb begin
      bus_adr = 11'd0;
      bus_dat = 32'd0;
      bus_we  = 1'b0;
      if (cyc_reg) begin
         case (state_reg)
            W_SRC: begin bus_adr = DMA_REG_BASE + 11'd16; bus_dat = job_src_reg; bus_we = 1'b1; end
            W_DST: begin bus_adr = DMA_REG_BASE + 11'd17; bus_dat = job_dst_reg; bus_we = 1'b1; end
            W_LEN: begin bus_adr = DMA_REG_BASE + 11'd18; bus_dat = job_len_reg; bus_we = 1'b1; end
            W_CMD: begin bus_adr = DMA_REG_BASE + 11'd19; bus_dat = job_cmd_reg; bus_we = 1'b1; end
            R_IRQ: bus_adr = DMA_REG_BASE;
            C_IRQ: begin bus_adr = DMA_REG_BASE; bus_dat = pend_reg; bus_we = 1'b1; end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_picorv_dma_sched.sv
// tb_picorv_dma_sched: table-driven host register checks plus directed job
// sequences against a behavioural DMA register-port model.
module tb_picorv_dma_sched;
   logic        sys_clk = 1'b0;
   logic        rst;
   logic [2:0]  wbs_adr;
   logic [31:0] wbs_dat_w, wbs_dat_r;
   logic [3:0]  wbs_sel;
   logic        wbs_cyc, wbs_stb, wbs_we, wbs_ack, wbs_stall;
   logic [10:0] dma_adr_o;
   logic [31:0] dma_dat_o;
   logic [31:0] dma_dat_i = 32'd0;
   logic        dma_we_o;
   logic [3:0]  dma_sel_o;
   logic        dma_cyc_o, dma_stb_o;
   logic        dma_ack_i = 1'b0;
   logic        dma_stall_i;
   logic        dma_err_i = 1'b0;
   logic        dma_irq_i = 1'b0;
   logic        irq_o;

   int n_checks = 0;
   int n_fails  = 0;

   // bench-controlled knobs for the DMA model
   logic        irq_auto = 1'b0;
   logic        stall_en = 1'b0;
   logic [10:0] err_adr  = 11'd0;
   int          err_req  = 0;

   // DMA model state
   logic        pend = 1'b0;
   logic [10:0] pend_adr = 11'd0;
   logic        cmd_pending = 1'b0;
   int          irq_cnt = 0;
   int          err_served = 0;
   int          stall_cnt = 0;
   int          stb_dst_cycles = 0;
   int          dat_bad = 0;
   int          gap_viol = 0;
   logic        ack_prev = 1'b0;
   logic [10:0] log_adr[$];
   logic [31:0] log_dat[$];
   logic        log_we[$];

   always #5 sys_clk = ~sys_clk;

   picorv_dma_sched #(.QUEUE_DEPTH(4), .DMA_REG_BASE(11'd1024)) dut (
      .sys_clk(sys_clk), .rst(rst),
      .wbs_adr(wbs_adr), .wbs_dat_w(wbs_dat_w), .wbs_dat_r(wbs_dat_r), .wbs_sel(wbs_sel),
      .wbs_cyc(wbs_cyc), .wbs_stb(wbs_stb), .wbs_we(wbs_we), .wbs_ack(wbs_ack), .wbs_stall(wbs_stall),
      .dma_adr_o(dma_adr_o), .dma_dat_o(dma_dat_o), .dma_dat_i(dma_dat_i), .dma_we_o(dma_we_o),
      .dma_sel_o(dma_sel_o), .dma_cyc_o(dma_cyc_o), .dma_stb_o(dma_stb_o), .dma_ack_i(dma_ack_i),
      .dma_stall_i(dma_stall_i), .dma_err_i(dma_err_i), .dma_irq_i(dma_irq_i), .irq_o(irq_o)
   );

   // stall only the gp_reg[1] write, for its first three strobe cycles
   assign dma_stall_i = stall_en && dma_stb_o && (dma_adr_o == 11'd1041) && (stall_cnt < 3);

   // DMA register-port model: accept, ack one cycle later, log, raise irq after a cmd write
   always @(posedge sys_clk) begin
      dma_ack_i <= 1'b0;
      dma_err_i <= 1'b0;
      if (dma_stall_i) stall_cnt <= stall_cnt + 1;
      if (stall_en && dma_stb_o && dma_adr_o == 11'd1041) begin
         stb_dst_cycles <= stb_dst_cycles + 1;
         if (dma_dat_o != 32'h400) dat_bad <= dat_bad + 1;
      end
      if (ack_prev && dma_cyc_o) gap_viol <= gap_viol + 1;
      ack_prev <= dma_ack_i | dma_err_i;
      if (rst) begin
         pend        <= 1'b0;
         cmd_pending <= 1'b0;
      end else begin
         if (cmd_pending && irq_auto) begin
            if (irq_cnt == 0) begin
               dma_irq_i   <= 1'b1;
               cmd_pending <= 1'b0;
            end else begin
               irq_cnt <= irq_cnt - 1;
            end
         end
         if (pend) begin
            pend      <= 1'b0;
            dma_ack_i <= 1'b1;
            dma_dat_i <= {31'd0, dma_irq_i};
            if (pend_adr == err_adr && err_served < err_req) begin
               dma_err_i  <= 1'b1;
               err_served <= err_served + 1;
            end
         end else if (dma_cyc_o && dma_stb_o && !dma_stall_i) begin
            pend     <= 1'b1;
            pend_adr <= dma_adr_o;
            log_adr.push_back(dma_adr_o);
            log_dat.push_back(dma_we_o ? dma_dat_o : {31'd0, dma_irq_i});
            log_we.push_back(dma_we_o);
            if (dma_we_o && dma_adr_o == 11'd1043) begin
               cmd_pending <= 1'b1;
               irq_cnt     <= 9;
            end
            if (dma_we_o && dma_adr_o == 11'd1024 && dma_dat_o[0]) dma_irq_i <= 1'b0;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end else begin
         $display("ok   %s = 0x%08h", name, act);
      end
   endtask

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic host_xfer(input logic we, input logic [2:0] adr, input logic [31:0] wd,
                            output logic [31:0] rd);
      int n;
      wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_we = we; wbs_adr = adr; wbs_dat_w = wd;
      n = 0;
      do begin
         tick();
         n++;
      end while (!wbs_ack && n < 8);
      rd = wbs_dat_r;
      if (!wbs_ack) begin
         n_checks++;
         n_fails++;
         $display("FAIL host_ack_timeout: got no ack at adr %0d, required ack within 8 cycles", adr);
      end
      wbs_cyc = 1'b0; wbs_stb = 1'b0; wbs_we = 1'b0;
   endtask

   task automatic host_wr(input logic [2:0] adr, input logic [31:0] wd);
      logic [31:0] d;
      host_xfer(1'b1, adr, wd, d);
   endtask

   task automatic host_rd(input logic [2:0] adr, output logic [31:0] rd);
      host_xfer(1'b0, adr, 32'd0, rd);
   endtask

   task automatic wait_done(input int target, input int budget);
      logic [31:0] s;
      int n;
      n = 0;
      do begin
         host_rd(3'd4, s);
         n++;
      end while (s[15:8] != target[7:0] && n < budget);
      if (s[15:8] != target[7:0]) begin
         n_checks++;
         n_fails++;
         $display("FAIL wait_done_timeout: got done_cnt %0d, required %0d", s[15:8], target);
      end
   endtask

   task automatic push_job(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l,
                           input logic [31:0] c);
      host_wr(3'd0, s);
      host_wr(3'd1, d);
      host_wr(3'd2, l);
      host_wr(3'd3, c);
   endtask

   typedef struct packed {
      logic        we;
      logic [2:0]  adr;
      logic [31:0] wd;
      logic [31:0] exp;
   } vec_t;

   localparam int NV = 17;
   vec_t vecs[NV];

   initial begin
      #400000;
      $display("FAIL watchdog: got no end of test, required finish within 40000 cycles");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      logic [31:0] cmds[8];
      logic [31:0] srcs[8];
      int base, k, j, nlog;
      logic [10:0] exp_adr[6];
      logic [31:0] exp_dat[6];
      logic        exp_we[6];

      vecs[0]  = '{1'b0, 3'd4, 32'h0,        32'h0000_0004};
      vecs[1]  = '{1'b0, 3'd5, 32'h0,        32'h0};
      vecs[2]  = '{1'b0, 3'd6, 32'h0,        32'h0};
      vecs[3]  = '{1'b1, 3'd0, 32'hDEADBEEF, 32'h0};
      vecs[4]  = '{1'b0, 3'd0, 32'h0,        32'hDEADBEEF};
      vecs[5]  = '{1'b1, 3'd1, 32'h12345678, 32'h0};
      vecs[6]  = '{1'b0, 3'd1, 32'h0,        32'h12345678};
      vecs[7]  = '{1'b1, 3'd2, 32'hA5A5A5A5, 32'h0};
      vecs[8]  = '{1'b0, 3'd2, 32'h0,        32'hA5A5A5A5};
      vecs[9]  = '{1'b0, 3'd3, 32'h0,        32'h0};
      vecs[10] = '{1'b0, 3'd7, 32'h0,        32'h0};
      vecs[11] = '{1'b1, 3'd6, 32'hFFFFFFFF, 32'h0};
      vecs[12] = '{1'b0, 3'd6, 32'h0,        32'h7};
      vecs[13] = '{1'b1, 3'd5, 32'h7,        32'h0};
      vecs[14] = '{1'b0, 3'd5, 32'h0,        32'h0};
      vecs[15] = '{1'b1, 3'd6, 32'h0,        32'h0};
      vecs[16] = '{1'b0, 3'd6, 32'h0,        32'h0};

      rst = 1'b1; wbs_adr = 3'd0; wbs_dat_w = 32'd0; wbs_sel = 4'hF;
      wbs_cyc = 1'b0; wbs_stb = 1'b0; wbs_we = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      tick();

      // reset state
      check("rst_dma_cyc", {31'd0, dma_cyc_o}, 32'd0);
      check("rst_dma_stb", {31'd0, dma_stb_o}, 32'd0);
      check("rst_irq_o",   {31'd0, irq_o},     32'd0);
      check("rst_wbs_ack", {31'd0, wbs_ack},   32'd0);

      // host register table
      for (int i = 0; i < NV; i++) begin
         host_xfer(vecs[i].we, vecs[i].adr, vecs[i].wd, rd);
         if (!vecs[i].we) check($sformatf("vec%0d_rd_adr%0d", i, vecs[i].adr), rd, vecs[i].exp);
      end

      // single job end to end
      host_wr(3'd6, 32'h1);
      irq_auto = 1'b1;
      base = log_adr.size();
      push_job(32'h100, 32'h200, 32'h40, 32'h1);
      wait_done(1, 400);
      exp_adr = '{11'd1040, 11'd1041, 11'd1042, 11'd1043, 11'd1024, 11'd1024};
      exp_dat = '{32'h100, 32'h200, 32'h40, 32'h1, 32'h1, 32'h1};
      exp_we  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      check("single_log_len", log_adr.size() - base, 32'd6);
      for (int i = 0; i < 6; i++) begin
         if (base + i < log_adr.size()) begin
            check($sformatf("single_t%0d_adr", i), {21'd0, log_adr[base+i]}, {21'd0, exp_adr[i]});
            check($sformatf("single_t%0d_dat", i), log_dat[base+i], exp_dat[i]);
            check($sformatf("single_t%0d_we", i), {31'd0, log_we[base+i]}, {31'd0, exp_we[i]});
         end
      end
      host_rd(3'd4, rd);
      check("single_status", rd, 32'h0000_0104);
      host_rd(3'd5, rd);
      check("single_irq", rd, 32'h1);
      tick();
      check("single_irq_o", {31'd0, irq_o}, 32'd1);
      host_wr(3'd5, 32'h1);
      tick(); tick();
      check("single_irq_o_clr", {31'd0, irq_o}, 32'd0);
      host_rd(3'd5, rd);
      check("single_irq_clr", rd, 32'h0);

      // queue fill with the DMA irq held low
      rst = 1'b1; tick(); rst = 1'b0; tick();
      irq_auto = 1'b0;
      base = log_adr.size();
      host_wr(3'd1, 32'h2000);
      host_wr(3'd2, 32'h80);
      for (int i = 0; i < 5; i++) begin
         host_wr(3'd0, 32'h1000 + i);
         host_wr(3'd3, 32'h10 + i);
      end
      host_rd(3'd4, rd);
      check("fill_status", rd, 32'h0000_0023);
      host_wr(3'd3, 32'h99);
      host_rd(3'd5, rd);
      check("overflow_irq", rd, 32'h2);
      host_rd(3'd4, rd);
      check("overflow_status", rd, 32'h0000_0023);
      host_wr(3'd5, 32'h2);

      // back-to-back drain of 8 jobs across pointer wrap
      irq_auto = 1'b1;
      for (int i = 5; i < 8; i++) begin
         k = 0;
         do begin
            host_rd(3'd4, rd);
            k++;
         end while (rd[1] && k < 500);
         host_wr(3'd0, 32'h1000 + i);
         host_wr(3'd3, 32'h10 + i);
      end
      wait_done(8, 2000);
      k = 0; j = 0;
      for (int i = base; i < log_adr.size(); i++) begin
         if (log_we[i] && log_adr[i] == 11'd1043) begin
            if (k < 8) cmds[k] = log_dat[i];
            k++;
         end
         if (log_we[i] && log_adr[i] == 11'd1040) begin
            if (j < 8) srcs[j] = log_dat[i];
            j++;
         end
      end
      check("drain_cmd_count", k, 32'd8);
      check("drain_src_count", j, 32'd8);
      for (int i = 0; i < 8; i++) begin
         if (i < k) check($sformatf("drain_cmd%0d", i), cmds[i], 32'h10 + i);
         if (i < j) check($sformatf("drain_src%0d", i), srcs[i], 32'h1000 + i);
      end
      host_rd(3'd4, rd);
      check("drain_status", rd, 32'h0000_0804);

      // stall on the gp_reg[1] write
      stall_en = 1'b1;
      base = log_adr.size();
      push_job(32'h300, 32'h400, 32'h50, 32'h2);
      wait_done(9, 400);
      check("stall_stb_cycles", stb_dst_cycles, 32'd4);
      check("stall_dat_changed", dat_bad, 32'd0);
      check("stall_log_len", log_adr.size() - base, 32'd6);
      if (base + 1 < log_adr.size()) check("stall_dst_dat", log_dat[base+1], 32'h400);
      stall_en = 1'b0;

      // bus error on the gp_reg[2] write aborts that job only
      host_wr(3'd5, 32'h7);
      err_adr = 11'd1042;
      err_req = 1;
      base = log_adr.size();
      push_job(32'h500, 32'h600, 32'h70, 32'h30);
      push_job(32'h501, 32'h601, 32'h71, 32'h31);
      wait_done(10, 400);
      repeat (30) tick();
      host_rd(3'd4, rd);
      check("err_status", rd, 32'h0000_0A04);
      host_rd(3'd5, rd);
      check("err_irq", rd, 32'h5);
      k = 0; j = 0;
      for (int i = base; i < log_adr.size(); i++) begin
         if (log_we[i] && log_adr[i] == 11'd1043) begin
            k++;
            check("err_cmd_dat", log_dat[i], 32'h31);
         end
         if (log_we[i] && log_adr[i] == 11'd1042) j++;
      end
      check("err_cmd_writes", k, 32'd1);
      check("err_len_writes", j, 32'd2);
      if (base + 3 < log_adr.size()) begin
         check("err_next_adr", {21'd0, log_adr[base+3]}, 32'd1040);
         check("err_next_dat", log_dat[base+3], 32'h501);
      end

      // reset while waiting on the DMA irq with two jobs queued
      host_wr(3'd5, 32'h7);
      irq_auto = 1'b0;
      for (int i = 0; i < 3; i++) push_job(32'h700 + i, 32'h800, 32'h10, 32'h40 + i);
      repeat (40) tick();
      host_rd(3'd4, rd);
      check("prerst_status", rd, 32'h0000_0A11);
      rst = 1'b1;
      tick();
      check("rst_mid_cyc", {31'd0, dma_cyc_o}, 32'd0);
      rst = 1'b0;
      irq_auto = 1'b1;
      tick();
      host_rd(3'd4, rd);
      check("rst_mid_status", rd, 32'h4);
      nlog = log_adr.size();
      repeat (50) tick();
      check("rst_mid_no_writes", log_adr.size(), nlog);
      check("rst_mid_cyc_idle", {31'd0, dma_cyc_o}, 32'd0);

      check("dma_gap_violations", gap_viol, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule
